inst_fetch: RTL



---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/fetch_fifo2.sv | 49 ++++
 rtl/inst_fetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// fetch-state encoding, PC increment and the prefetch FIFO entry layout.
package inst_fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry synchronous FIFO holding fetched {pc, inst} pairs.
// Flush empties it and wins over push/pop. The caller never pushes into a
// full FIFO unless it pops in the same cycle, and never pops an empty one.
module fetch_fifo2 #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [1:0]        count_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;

  // Pointer and occupancy bookkeeping; flush discards everything, pops included.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  // Entry storage; when full with a pop, the write slot is the one being vacated.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !rst) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives the fetch PC to instruction memory, buffers
// {pc, inst} pairs in a 2-entry prefetch FIFO and hands them to decode.
// Optional macro IFU_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and
// raises fetch_trap until reset or a later aligned redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                         PC_WIDTH_LENGTH   = PC_W,
  parameter int                         INST_WIDTH_LENGTH = INST_W,
  parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC          = '0,
  parameter int                         FIFO_DEPTH        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [PC_WIDTH_LENGTH-1:0]   mem_pc,
  input  logic [INST_WIDTH_LENGTH-1:0] mem_inst,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [INST_WIDTH_LENGTH-1:0] id_inst,
  output logic [PC_WIDTH_LENGTH-1:0]   id_pc,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic                         fetch_trap
`endif
);

  typedef struct packed {
    logic [PC_WIDTH_LENGTH-1:0]   pc;
    logic [INST_WIDTH_LENGTH-1:0] inst;
  } entry_t;

  localparam int                         ENTRY_W    = PC_WIDTH_LENGTH + INST_WIDTH_LENGTH;
  localparam logic [PC_WIDTH_LENGTH-1:0] ALIGN_MASK = ~PC_WIDTH_LENGTH'(3);
  localparam logic [PC_WIDTH_LENGTH-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

  logic [PC_WIDTH_LENGTH-1:0] pc_q, pc_d;
  fetch_state_e               state_q, state_d;
  logic                       pop;
  logic                       push;
  logic [1:0]                 count;
  entry_t                     wentry;
  entry_t                     hentry;

`ifdef IFU_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  logic misaligned;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign fetch_trap = trap_q;
`endif

  assign mem_pc = pc_q;
  assign pop    = id_valid & id_ready;
  assign push   = (state_q == FETCH) & ((count < 2'd2) | pop) & ~redirect_valid;
  assign wentry = '{pc: pc_q, inst: mem_inst};

  fetch_fifo2 #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (wentry),
    .count_o (count),
    .valid_o (id_valid),
    .head_o  (hentry)
  );

  assign id_pc   = hentry.pc;
  assign id_inst = hentry.inst;

  // Next PC/state: a redirect beats everything else, otherwise a push advances the PC.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
`ifdef IFU_MISALIGN_TRAP_EN
    trap_d  = trap_q;
`endif
    if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
`ifdef IFU_MISALIGN_TRAP_EN
      state_d = misaligned ? HALT : FETCH;
      trap_d  = misaligned;
`else
      state_d = FETCH;
`endif
    end else if (push) begin
      pc_d = pc_q + PC_WIDTH_LENGTH'(PC_STEP);
    end
  end

  // PC, state and trap registers with reset to the aligned reset vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC_A;
      state_q <= FETCH;
`ifdef IFU_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
`ifdef IFU_MISALIGN_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

endmodule
